// File: rtl/cargador_de_instrucciones_pkg.sv
// Shared definitions for the byte-serial instruction loader: FSM state
// encoding, protocol widths and the word-address helper.
package cargador_de_instrucciones_pkg;

    // Width of the big-endian word count that prefixes every session.
    localparam int LEN_WIDTH        = 16;
    // Bytes per instruction word and the derived widths.
    localparam int WORD_BYTES       = 4;
    localparam int WORD_BITS        = WORD_BYTES * 8;
    localparam int BYTE_INDEX_WIDTH = $clog2(WORD_BYTES);

    typedef logic [LEN_WIDTH-1:0] longitud_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        BYTES  = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } estado_t;

    // Byte address of word 'index' relative to 'base'; wraps in 32 bits.
    function automatic logic [31:0] word_address(input logic [31:0] base,
                                                 input longitud_t   index);
        return base + {{(32 - LEN_WIDTH - 2){1'b0}}, index, 2'b00};
    endfunction

endpackage

// File: rtl/cargador_de_instrucciones_ensamblador_de_palabra.sv
// Big-endian word assembler: shifts stream bytes in from the low end so the
// first byte of a word ends up in the top byte lane.
module ensamblador_de_palabra
    import cargador_de_instrucciones_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_shift,
    input  logic [7:0]                  i_byte,
    output logic [WORD_BITS-1:0]        o_word,
    output logic [BYTE_INDEX_WIDTH-1:0] o_index,
    output logic                        o_last_byte,
    output logic                        o_word_complete
);

    // The byte being shifted in this cycle completes the word.
    assign o_last_byte = (o_index == BYTE_INDEX_WIDTH'(WORD_BYTES - 1));

    // Shift register, byte index (wraps 3->0) and completion flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_word          <= '0;
            o_index         <= '0;
            o_word_complete <= 1'b0;
        end else if (i_clear) begin
            o_index         <= '0;
            o_word_complete <= 1'b0;
        end else if (i_shift) begin
            o_word          <= {o_word[WORD_BITS-9:0], i_byte};
            o_index         <= o_index + 1'b1;
            o_word_complete <= o_last_byte;
        end
    end

endmodule

// File: rtl/cargador_de_instrucciones.sv
// Byte-serial program loader: takes a length-prefixed byte stream, writes
// big-endian instruction words into instruction memory one per WRITE cycle,
// and keeps the CPU held until a program has loaded successfully.
module cargador_de_instrucciones
    import cargador_de_instrucciones_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_mem_write_enable,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_data,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_words_loaded
);

    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(MAX_WORDS);

    estado_t                     state;
    estado_t                     next_state;
    longitud_t                   length;
    longitud_t                   length_next;
    logic                        accept;
    logic                        start_session;
    logic                        asm_clear;
    logic                        asm_shift;
    logic [WORD_BITS-1:0]        asm_word;
    logic [BYTE_INDEX_WIDTH-1:0] asm_index;
    logic                        asm_last_byte;
    logic                        asm_word_complete;

    // A byte moves only when both sides agree on the same edge.
    assign accept        = i_byte_valid & o_byte_ready;
    // i_start is honoured only when no session is in flight.
    assign start_session = i_start &&
                           (state == IDLE || state == DONE || state == ERROR);
    // Full count as it will be once the low byte lands this cycle.
    assign length_next   = {length[LEN_WIDTH-1:8], i_byte};
    assign asm_shift     = (state == BYTES) && accept;
    assign asm_clear     = start_session || (state == WRITE);

    ensamblador_de_palabra u_ensamblador (
        .clk             (clk),
        .reset           (reset),
        .i_clear         (asm_clear),
        .i_shift         (asm_shift),
        .i_byte          (i_byte),
        .o_word          (asm_word),
        .o_index         (asm_index),
        .o_last_byte     (asm_last_byte),
        .o_word_complete (asm_word_complete)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Session length, latched high byte first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            length <= '0;
        end else if (accept && state == LEN_HI) begin
            length[LEN_WIDTH-1:8] <= i_byte;
        end else if (accept && state == LEN_LO) begin
            length[7:0] <= i_byte;
        end
    end

    // Words written this session; also the address offset of the next write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              o_words_loaded <= '0;
        else if (start_session)  o_words_loaded <= '0;
        else if (state == WRITE) o_words_loaded <= o_words_loaded + 1'b1;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (i_start) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (accept) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (length_next == '0)                    next_state = DONE;
                    else if ({1'b0, length_next} > MAX_LEN)   next_state = ERROR;
                    else                                      next_state = BYTES;
                end
            end
            BYTES: begin
                if (accept && asm_last_byte) next_state = WRITE;
            end
            WRITE: begin
                if (o_words_loaded + 1'b1 == length) next_state = DONE;
                else                                 next_state = BYTES;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        o_byte_ready       = (state == LEN_HI) || (state == LEN_LO) || (state == BYTES);
        o_mem_write_enable = (state == WRITE) && asm_word_complete;
        o_mem_data         = o_mem_write_enable ? asm_word : '0;
        o_mem_address      = word_address(BASE_ADDRESS, o_words_loaded);
        o_cpu_hold         = (state != DONE);
        o_done             = (state == DONE);
        o_error            = (state == ERROR);
    end

    // The index is consumed through asm_last_byte; keep it visible for debug.
    logic unused_index;
    assign unused_index = ^asm_index;

endmodule

// File: tb/tb_cargador_de_instrucciones.sv
// Self-checking bench for cargador_de_instrucciones. A monitor records every
// memory write; a reference model derives the expected writes and final
// status directly from the byte stream of each session.
module tb_cargador_de_instrucciones;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          MAX_W = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic        o_mem_write_enable;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_data;
    logic        o_cpu_hold;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_words_loaded;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        ready;
    } wr_t;

    wr_t writes[$];

    cargador_de_instrucciones #(
        .BASE_ADDRESS (BASE),
        .MAX_WORDS    (MAX_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_start            (i_start),
        .i_byte             (i_byte),
        .i_byte_valid       (i_byte_valid),
        .o_byte_ready       (o_byte_ready),
        .o_mem_write_enable (o_mem_write_enable),
        .o_mem_address      (o_mem_address),
        .o_mem_data         (o_mem_data),
        .o_cpu_hold         (o_cpu_hold),
        .o_done             (o_done),
        .o_error            (o_error),
        .o_words_loaded     (o_words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled away from the rising edge.
    always @(negedge clk) begin
        if (o_mem_write_enable === 1'b1)
            writes.push_back('{o_mem_address, o_mem_data, o_byte_ready});
    end

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Drive a byte stream; mode 0 = valid always, 1 = toggling, 2 = random.
    task automatic send_bytes(input logic [7:0] s[$], input int mode,
                              input bit poke_start, output bit ok);
        int idx    = 0;
        int cyc    = 0;
        int budget = s.size() * 8 + 100;
        bit v;
        bit tog    = 1'b1;
        while (idx < s.size() && cyc < budget) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            i_byte_valid = v;
            i_byte       = v ? s[idx] : 8'($urandom);
            i_start      = poke_start && (idx > 0) && ($urandom_range(0, 7) == 0);
            if (v && o_byte_ready === 1'b1) idx++;
            @(negedge clk);
            cyc++;
        end
        i_byte_valid = 1'b0;
        i_start      = 1'b0;
        ok = (idx == s.size());
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (o_done === 1'b1 || o_error === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    // Reference model: expected writes and final status from the stream.
    task automatic score_session(input string name, input logic [7:0] s[$],
                                 input int base);
        int  n;
        bit  exp_err;
        int  exp_n;
        int  got;
        logic [31:0] exp_data;
        n       = (int'(s[0]) << 8) | int'(s[1]);
        exp_err = (n > MAX_W);
        exp_n   = exp_err ? 0 : n;
        got     = writes.size() - base;
        checks++;
        if (got !== exp_n) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, got, exp_n);
        end
        for (int i = 0; i < exp_n && i < got; i++) begin
            exp_data = {s[2 + 4*i], s[3 + 4*i], s[4 + 4*i], s[5 + 4*i]};
            checks++;
            if (writes[base + i].addr !== BASE + 32'(4 * i) ||
                writes[base + i].data !== exp_data ||
                writes[base + i].ready !== 1'b0) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr %h data %h ready %b expected addr %h data %h ready 0",
                         name, i, writes[base + i].addr, writes[base + i].data,
                         writes[base + i].ready, BASE + 32'(4 * i), exp_data);
            end
        end
        checks++;
        if (o_done !== !exp_err || o_error !== exp_err || o_cpu_hold !== exp_err ||
            o_words_loaded !== 16'(exp_n) || o_byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s status: got done %b error %b hold %b words %0d ready %b expected done %b error %b hold %b words %0d ready 0",
                     name, o_done, o_error, o_cpu_hold, o_words_loaded, o_byte_ready,
                     !exp_err, exp_err, exp_err, exp_n);
        end
    endtask

    task automatic run_session(input string name, input logic [7:0] s[$],
                               input int mode, input bit poke);
        int base;
        bit ok;
        base = writes.size();
        pulse_start();
        send_bytes(s, mode, poke, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s send_timeout: stream not consumed within budget", name);
        end
        wait_end(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s end_timeout: got done %b error %b expected one of them set",
                     name, o_done, o_error);
        end
        score_session(name, s, base);
    endtask

    function automatic void make_stream(output logic [7:0] s[$], input int n);
        s = {};
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        if (n <= MAX_W)
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (o_cpu_hold !== 1'b1 || o_byte_ready !== 1'b0 || o_done !== 1'b0 ||
            o_error !== 1'b0 || o_words_loaded !== 16'd0 || o_mem_address !== BASE ||
            o_mem_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got hold %b ready %b done %b error %b words %0d addr %h data %h expected 1 0 0 0 0 %h 0",
                     o_cpu_hold, o_byte_ready, o_done, o_error, o_words_loaded,
                     o_mem_address, o_mem_data, BASE);
        end
        checks++;
        if (writes.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d writes expected 0", writes.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        int base;
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
        base = writes.size();
        run_session("basic", s, 0, 1'b0);
        checks++;
        if (writes.size() < base + 2 || writes[base].data !== 32'h2008_0005 ||
            writes[base + 1].addr !== 32'h4 || writes[base + 1].data !== 32'h0000_0008) begin
            errors++;
            $display("FAIL basic_literal: expected 0x0:20080005 then 0x4:00000008, got %0d writes",
                     writes.size() - base);
        end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
        run_session("toggle", s, 1, 1'b0);
    endtask

    task automatic test_error_then_recover();
        logic [7:0] s[$];
        s = '{8'h01, 8'h01};
        run_session("too_long", s, 0, 1'b0);
        s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_session("recover", s, 0, 1'b0);
    endtask

    task automatic test_zero_length();
        logic [7:0] s[$];
        s = '{8'h00, 8'h00};
        run_session("zero_len", s, 0, 1'b0);
    endtask

    task automatic test_max_length();
        logic [7:0] s[$];
        make_stream(s, MAX_W);
        run_session("max_len", s, 0, 1'b0);
    endtask

    task automatic test_reset_mid_session();
        logic [7:0] s[$];
        int base;
        bit ok;
        logic [31:0] exp_data;
        make_stream(s, 3);
        exp_data = {s[2], s[3], s[4], s[5]};
        s = s[0:7];
        base = writes.size();
        pulse_start();
        send_bytes(s, 0, 1'b0, ok);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (o_cpu_hold !== 1'b1 || o_byte_ready !== 1'b0 || o_mem_write_enable !== 1'b0 ||
            o_done !== 1'b0 || o_error !== 1'b0 || o_words_loaded !== 16'd0 ||
            o_mem_address !== BASE || o_mem_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_async: got hold %b ready %b we %b done %b error %b words %0d addr %h data %h expected reset values",
                     o_cpu_hold, o_byte_ready, o_mem_write_enable, o_done, o_error,
                     o_words_loaded, o_mem_address, o_mem_data);
        end
        checks++;
        if (!ok || writes.size() - base !== 1 || writes[base].addr !== BASE ||
            writes[base].data !== exp_data) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes expected 1 at %h data %h",
                     writes.size() - base, BASE, exp_data);
        end
        @(negedge clk);
        reset = 1'b1;
        make_stream(s, 2);
        run_session("after_reset", s, 2, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        int n;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = MAX_W + 1 + $urandom_range(0, 500);
                default: n = $urandom_range(1, 9);
            endcase
            make_stream(s, n);
            run_session($sformatf("random%0d", k), s, 2, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_valid();
        test_error_then_recover();
        test_zero_length();
        test_max_length();
        test_reset_mid_session();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
